// File: rtl/floor_request_dispatcher_if.sv
// floor_request_dispatcher_if
//   Bundles the call-panel / elevator-controller signals seen by the
//   floor request dispatcher.
//   Ports (FLOORS-wide vectors, bit i = floor i):
//     call_buttons   panel -> dispatcher, call presses (level or pulse)
//     current_floor  controller -> dispatcher, one-hot car position
//     complete       controller -> dispatcher, arrival indication
//     request_floor  dispatcher -> controller, one-hot target (registered)
//     request_valid  dispatcher -> controller, request outstanding
//     pending        dispatcher -> lamps, outstanding calls
//     sweep_up       current sweep direction, 1 = up
//     door_open      high while the door dwells after a serve
//     fault          watchdog fault flag
//   Modports: slave = dispatcher side, master = environment side.
interface floor_request_dispatcher_if #(
  parameter int FLOORS = 8
);
  logic [FLOORS-1:0] call_buttons;
  logic [FLOORS-1:0] current_floor;
  logic              complete;
  logic [FLOORS-1:0] request_floor;
  logic              request_valid;
  logic [FLOORS-1:0] pending;
  logic              sweep_up;
  logic              door_open;
  logic              fault;

  modport slave (
    input  call_buttons, current_floor, complete,
    output request_floor, request_valid, pending, sweep_up, door_open, fault
  );

  modport master (
    output call_buttons, current_floor, complete,
    input  request_floor, request_valid, pending, sweep_up, door_open, fault
  );
endinterface

// File: rtl/floor_request_dispatcher.sv
// floor_request_dispatcher
//   Latches per-floor call presses, chooses the next target floor with a
//   SCAN (sweep) policy, holds the one-hot request until the controller
//   reports completion at that floor, then dwells with the door open.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    floor_request_dispatcher_if.slave (see interface header)
//   Parameters: FLOORS (must match the interface), DWELL_CYCLES,
//   TIMEOUT_CYCLES.
//   Optional feature: define DISPATCH_TIMEOUT_EN to enable the SERVE-state
//   watchdog and the FAULT state; otherwise fault is tied low and SERVE
//   waits indefinitely.
module floor_request_dispatcher #(
  parameter int FLOORS         = 8,
  parameter int DWELL_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                      clk,
  input logic                      reset,
  floor_request_dispatcher_if.slave bus
);

  // One counter serves both the dwell interval and the watchdog.
  localparam int CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
`ifdef DISPATCH_TIMEOUT_EN
    ST_DWELL = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_DWELL = 2'd2
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [FLOORS-1:0] request_floor_reg, request_floor_next;
  logic [FLOORS-1:0] pending_reg, pending_next;
  logic              sweep_up_reg, sweep_up_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [FLOORS-1:0] above_mask;   // floors strictly above the car
  logic [FLOORS-1:0] below_mask;   // floors strictly below the car
  logic [FLOORS-1:0] pend_above, pend_below;
  logic [FLOORS-1:0] lowest_above, highest_below;
  logic [FLOORS-1:0] clear_mask, press_mask;
  logic              floor_ok, at_floor, arrived;

  function automatic logic [FLOORS-1:0] msb_onehot(input logic [FLOORS-1:0] v);
    logic [FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_masks
      localparam logic [FLOORS-1:0] LOWER = FLOORS'((64'd1 << gi) - 64'd1);
      localparam logic [FLOORS-1:0] SELF  = FLOORS'(64'd1 << gi);
      assign above_mask[gi] = |(bus.current_floor & LOWER);
      assign below_mask[gi] = |(bus.current_floor & ~LOWER & ~SELF);
    end
  endgenerate

  // Position is usable only when exactly one bit is set.
  assign floor_ok      = (bus.current_floor != '0) &&
                         ((bus.current_floor & (bus.current_floor - FLOORS'(1))) == '0);
  assign pend_above    = pending_reg & above_mask;
  assign pend_below    = pending_reg & below_mask;
  assign lowest_above  = pend_above & (~pend_above + FLOORS'(1));
  assign highest_below = msb_onehot(pend_below);
  assign at_floor      = |(pending_reg & bus.current_floor);
  assign arrived       = bus.complete && (bus.current_floor == request_floor_reg);

  // A press of the floor already being served (or just served) is dropped
  // so the lamp does not relight for a call that is being answered.
  assign press_mask   = bus.call_buttons &
                        ~(((state_reg == ST_SERVE) || (state_reg == ST_DWELL)) ? request_floor_reg : '0);
  assign pending_next = (pending_reg | press_mask) & ~clear_mask;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      request_floor_reg <= '0;
      pending_reg       <= '0;
      sweep_up_reg      <= 1'b1;
      cnt_reg           <= '0;
    end else begin
      state_reg         <= state_next;
      request_floor_reg <= request_floor_next;
      pending_reg       <= pending_next;
      sweep_up_reg      <= sweep_up_next;
      cnt_reg           <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next         = state_reg;
    request_floor_next = request_floor_reg;
    sweep_up_next      = sweep_up_reg;
    clear_mask         = '0;
    cnt_next           = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (floor_ok && (pending_reg != '0)) begin
          if (at_floor) begin
            // Call at the car's floor is answered by opening the door only.
            clear_mask = bus.current_floor;
            state_next = ST_DWELL;
          end else begin
            if (sweep_up_reg) begin
              if (pend_above != '0) begin
                request_floor_next = lowest_above;
              end else begin
                request_floor_next = highest_below;
                sweep_up_next      = 1'b0;
              end
            end else begin
              if (pend_below != '0) begin
                request_floor_next = highest_below;
              end else begin
                request_floor_next = lowest_above;
                sweep_up_next      = 1'b1;
              end
            end
            state_next = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (arrived) begin
          clear_mask = request_floor_reg;
          state_next = ST_DWELL;
          cnt_next   = '0;
        end else begin
`ifdef DISPATCH_TIMEOUT_EN
          if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_next = ST_FAULT;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
`endif
        end
      end
      ST_DWELL: begin
        if (cnt_reg == CNT_W'(DWELL_CYCLES - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`ifdef DISPATCH_TIMEOUT_EN
      ST_FAULT: begin
        // Sticky until reset; pending keeps latching presses.
        state_next = ST_FAULT;
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.request_floor = request_floor_reg;
    bus.pending       = pending_reg;
    bus.sweep_up      = sweep_up_reg;
    bus.request_valid = (state_reg == ST_SERVE);
    bus.door_open     = (state_reg == ST_DWELL);
`ifdef DISPATCH_TIMEOUT_EN
    bus.fault         = (state_reg == ST_FAULT);
`else
    bus.fault         = 1'b0;
`endif
  end

endmodule

// File: tb/tb_floor_request_dispatcher.sv
module tb_floor_request_dispatcher;
  localparam int F     = 8;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  floor_request_dispatcher_if #(.FLOORS(F)) bus ();

  floor_request_dispatcher #(.FLOORS(F), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit         is_req;
    logic [7:0] floor;
    bit         up;
    logic [7:0] pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: set of pending calls, car floor index, sweep direction
  logic [7:0] m_pending;
  int         m_floor;
  bit         m_up;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // SCAN rule from the call list: nearest call ahead in the sweep direction,
  // otherwise nearest call behind with the direction reversed.
  function automatic void scan_pick(input logic [7:0] p, input int fl, input bit up,
                                    output int tgt, output bit nup);
    int above = -1;
    int below = -1;
    for (int f = fl + 1; f < F; f++) if (p[f] && above < 0) above = f;
    for (int f = fl - 1; f >= 0; f--) if (p[f] && below < 0) below = f;
    if (up) begin
      if (above >= 0) begin tgt = above; nup = 1'b1; end
      else            begin tgt = below; nup = 1'b0; end
    end else begin
      if (below >= 0) begin tgt = below; nup = 1'b0; end
      else            begin tgt = above; nup = 1'b1; end
    end
  endfunction

  // ---------------- monitor ----------------
  bit   prev_rv, prev_door;
  int   door_len;
  exp_t e;

  always @(negedge clk) begin
    if (reset) begin
      prev_rv   = 1'b0;
      prev_door = 1'b0;
      door_len  = 0;
    end else begin
      if (bus.request_valid && !prev_rv) begin
        $display("t=%0t request floor=%02h sweep_up=%0d pending=%02h",
                 $time, bus.request_floor, bus.sweep_up, bus.pending);
        chk("sb_has_req", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("event_kind_req", 1, int'(e.is_req));
          chk("request_floor", int'(bus.request_floor), int'(e.floor));
          chk("sweep_up_req", int'(bus.sweep_up), int'(e.up));
          chk("pending_req", int'(bus.pending), int'(e.pend));
          chk("fault_req", int'(bus.fault), 0);
        end
      end
      if (bus.door_open && !prev_door) begin
        door_len = 0;
        $display("t=%0t door open pending=%02h sweep_up=%0d", $time, bus.pending, bus.sweep_up);
        chk("sb_has_dwell", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("event_kind_dwell", 0, int'(e.is_req));
          chk("pending_dwell", int'(bus.pending), int'(e.pend));
          chk("sweep_up_dwell", int'(bus.sweep_up), int'(e.up));
          chk("rv_low_dwell", int'(bus.request_valid), 0);
          chk("fault_dwell", int'(bus.fault), 0);
        end
      end
      if (bus.door_open) door_len++;
      if (!bus.door_open && prev_door) chk("door_len", door_len, DWELL);
      prev_rv   = bus.request_valid;
      prev_door = bus.door_open;
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [7:0] m);
    @(negedge clk) bus.call_buttons = m;
    @(negedge clk) bus.call_buttons = 8'h00;
  endtask

  task automatic wait_rv(input logic level);
    int n = 0;
    while (bus.request_valid !== level && n < 20) begin @(negedge clk); n++; end
    chk("wait_request_valid", int'(bus.request_valid), int'(level));
  endtask

  task automatic wait_door(input logic level);
    int n = 0;
    while (bus.door_open !== level && n < 20) begin @(negedge clk); n++; end
    chk("wait_door_open", int'(bus.door_open), int'(level));
  endtask

  task automatic issue_next(input bit lat, output int tgt);
    bit nup;
    scan_pick(m_pending, m_floor, m_up, tgt, nup);
    m_up = nup;
    sb.push_back('{1'b1, 8'(1 << tgt), nup, m_pending});
    if (lat) begin
      @(negedge clk);
      chk("req_latency", int'(bus.request_valid), 1);
    end else begin
      wait_rv(1'b1);
    end
  endtask

  task automatic finish_serve(input int tgt, input bit mism);
    logic [7:0] r;
    int o;
    r = ($urandom_range(0, 3) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
    if (r != 8'd0) begin
      m_pending = m_pending | (r & ~(8'd1 << tgt));
      press(r);
    end
    if (mism) begin
      o = (tgt + 1 + $urandom_range(0, 6)) % F;
      @(negedge clk);
      bus.current_floor = 8'd1 << o;
      bus.complete = 1'b1;
      @(negedge clk);
      bus.complete = 1'b0;
      chk("mismatch_holds_request", int'(bus.request_valid), 1);
    end
    @(negedge clk);
    bus.current_floor = 8'd1 << tgt;
    bus.complete = 1'b1;
    m_pending[tgt] = 1'b0;
    m_floor = tgt;
    sb.push_back('{1'b0, 8'h00, m_up, m_pending});
    @(negedge clk);
    bus.complete = 1'b0;
    wait_door(1'b0);
  endtask

  task automatic serve_one(input bit lat, input bit mism);
    int tgt;
    if (m_pending[m_floor]) begin
      m_pending[m_floor] = 1'b0;
      sb.push_back('{1'b0, 8'h00, m_up, m_pending});
      wait_door(1'b1);
      wait_door(1'b0);
    end else begin
      issue_next(lat, tgt);
      finish_serve(tgt, mism);
    end
  endtask

  task automatic run_until_idle(input bit lat, input bit mism);
    bit first = lat;
    int guard = 0;
    while (m_pending != 8'h00 && guard < 40) begin
      serve_one(first, mism | ($urandom_range(0, 2) == 0));
      first = 1'b0;
      guard++;
    end
    chk("model_drained", int'(m_pending), 0);
  endtask

  task automatic move_car(input int fl);
    @(negedge clk);
    m_floor = fl;
    bus.current_floor = 8'(1 << fl);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int tgt;
    logic [7:0] m;
    reset = 1'b1;
    bus.call_buttons  = 8'h00;
    bus.current_floor = 8'h01;
    bus.complete      = 1'b0;
    m_pending = 8'h00; m_floor = 0; m_up = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_request_floor", int'(bus.request_floor), 0);
    chk("rst_request_valid", int'(bus.request_valid), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_sweep_up", int'(bus.sweep_up), 1);
    chk("rst_door_open", int'(bus.door_open), 0);
    chk("rst_fault", int'(bus.fault), 0);
    reset = 1'b0;

    // Basic serve: car at floor 0, call floor 3
    m_pending |= 8'h08; press(8'h08); run_until_idle(1'b1, 1'b0);

    // SCAN order from floor 2 sweeping up: 7, then 1, then 0
    move_car(2);
    m_pending |= 8'h83; press(8'h83); run_until_idle(1'b1, 1'b0);

    // Call at the car's own floor
    move_car(4);
    m_pending |= 8'h10; press(8'h10); run_until_idle(1'b0, 1'b0);

    // Mismatched arrival while serving floor 5
    move_car(1);
    m_pending |= 8'h20; press(8'h20); run_until_idle(1'b1, 1'b1);

    // Invalid position blocks dispatch
    @(negedge clk) bus.current_floor = 8'h00;
    m_pending |= 8'h40; press(8'h40);
    repeat (4) @(negedge clk);
    chk("nofloor_no_request", int'(bus.request_valid), 0);
    chk("nofloor_no_door", int'(bus.door_open), 0);
    chk("nofloor_pending", int'(bus.pending), int'(m_pending));
    @(negedge clk) bus.current_floor = 8'h24;
    repeat (3) @(negedge clk);
    chk("twohot_no_request", int'(bus.request_valid), 0);
    @(negedge clk) bus.current_floor = 8'(1 << m_floor);
    run_until_idle(1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) move_car($urandom_range(0, 7));
      m = 8'($urandom) & 8'($urandom);
      if (m == 8'h00) m = 8'd1 << $urandom_range(0, 7);
      m_pending |= m;
      press(m);
      run_until_idle(1'b1, 1'b0);
    end

    // Long SERVE with no completion
    m = 8'(1 << ((m_floor + 3) % F));
    m_pending |= m; press(m); issue_next(1'b1, tgt);
    repeat (70) @(negedge clk);
`ifdef DISPATCH_TIMEOUT_EN
    chk("timeout_fault", int'(bus.fault), 1);
    chk("timeout_rv_low", int'(bus.request_valid), 0);
    chk("timeout_door_low", int'(bus.door_open), 0);
    m = 8'(1 << ((tgt + 1) % F));
    m_pending |= m; press(m);
    repeat (3) @(negedge clk);
    chk("fault_pending_latch", int'(bus.pending), int'(m_pending));
    chk("fault_no_dispatch", int'(bus.request_valid), 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m_pending = 8'h00; m_up = 1'b1;
`else
    chk("no_timeout_fault", int'(bus.fault), 0);
    chk("no_timeout_rv", int'(bus.request_valid), 1);
    finish_serve(tgt, 1'b0);
    run_until_idle(1'b0, 1'b0);
`endif

    // Reset in the middle of SERVE with calls 0 and 6 outstanding
    move_car(3);
    m_pending |= 8'h41; press(8'h41); issue_next(1'b1, tgt);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("midrst_request_floor", int'(bus.request_floor), 0);
    chk("midrst_request_valid", int'(bus.request_valid), 0);
    chk("midrst_pending", int'(bus.pending), 0);
    chk("midrst_sweep_up", int'(bus.sweep_up), 1);
    chk("midrst_door_open", int'(bus.door_open), 0);
    chk("midrst_fault", int'(bus.fault), 0);
    reset = 1'b0;
    m_pending = 8'h00; m_up = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", int'(bus.request_valid), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
